// File: rtl/calc_keypad_pkg.sv
// Shared definitions for the keypad conditioning block: S2 state encoding and
// default timing constants tied to the 100 Hz debounce clock.
package calc_keypad_pkg;

  localparam int DB_CNT_DEF   = 3;
  localparam int LONG_CNT_DEF = 100;
  localparam int HOLD_W_DEF   = 7;

  typedef enum logic [1:0] {
    KS_LOCKED  = 2'd0,
    KS_IDLE    = 2'd1,
    KS_PRESSED = 2'd2,
    KS_LONG    = 2'd3
  } ks_state_e;

endpackage

// File: rtl/calc_keypad_key_debounce.sv
// One key front end: two-flop synchronizer, agreement counter and the accepted
// (stable) level, plus a strobe marking the edge on which a change is accepted.
module key_debounce
  import calc_keypad_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEF
) (
  input  logic clk_db,
  input  logic rst,
  input  logic i_key,
  output logic o_stable,
  output logic o_accept
);

  localparam int CW = $clog2(DB_CNT + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  assign w_accept = (r_sync2 != r_stable) && (r_cnt == CW'(DB_CNT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_db) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_cnt    <= '0;
      r_stable <= 1'b1;  // a key held through reset counts as already pressed
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_accept = w_accept;

endmodule

// File: rtl/calc_keypad.sv
// Keypad conditioning: debounces S0/S2/S3 and turns them into one-cycle
// command pulses (left/right with collision veto, S2 short/long classification).
module calc_keypad
  import calc_keypad_pkg::*;
#(
  parameter int DB_CNT   = DB_CNT_DEF,
  parameter int LONG_CNT = LONG_CNT_DEF,
  parameter int HOLD_W   = HOLD_W_DEF
) (
  input  logic clk_db,
  input  logic rst,
  input  logic key_s0,
  input  logic key_s2,
  input  logic key_s3,
  output logic btn_left,
  output logic btn_right,
  output logic s2_short,
  output logic s2_long,
  output logic s2_held
);

  logic w_s0_stable, w_s0_acc;
  logic w_s2_stable, w_s2_acc;
  logic w_s3_stable, w_s3_acc;
  logic w_s0_rise, w_s3_rise, w_s2_rise, w_s2_fall;

  key_debounce #(.DB_CNT(DB_CNT)) u_s0 (
    .clk_db(clk_db), .rst(rst), .i_key(key_s0), .o_stable(w_s0_stable), .o_accept(w_s0_acc)
  );
  key_debounce #(.DB_CNT(DB_CNT)) u_s2 (
    .clk_db(clk_db), .rst(rst), .i_key(key_s2), .o_stable(w_s2_stable), .o_accept(w_s2_acc)
  );
  key_debounce #(.DB_CNT(DB_CNT)) u_s3 (
    .clk_db(clk_db), .rst(rst), .i_key(key_s3), .o_stable(w_s3_stable), .o_accept(w_s3_acc)
  );

  // An accepted change flips the level, so the pre-edge level tells its direction.
  assign w_s0_rise = w_s0_acc & ~w_s0_stable;
  assign w_s3_rise = w_s3_acc & ~w_s3_stable;
  assign w_s2_rise = w_s2_acc & ~w_s2_stable;
  assign w_s2_fall = w_s2_acc &  w_s2_stable;

  logic r_btn_left, r_btn_right;

  always_ff @(posedge clk_db) begin
    if (rst) begin
      r_btn_left  <= 1'b0;
      r_btn_right <= 1'b0;
    end else begin
      r_btn_left  <= w_s0_rise & ~w_s3_rise;
      r_btn_right <= w_s3_rise & ~w_s0_rise;
    end
  end

  ks_state_e         r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic              r_short, w_short_nxt;
  logic              r_long, w_long_nxt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_short_nxt = 1'b0;
    w_long_nxt  = 1'b0;
    case (r_state)
      KS_LOCKED: begin
        w_hold_nxt = '0;
        if (!w_s2_stable) w_state_nxt = KS_IDLE;
      end
      KS_IDLE: begin
        w_hold_nxt = '0;
        if (w_s2_rise) w_state_nxt = KS_PRESSED;
      end
      KS_PRESSED: begin
        if (w_s2_fall) begin
          w_short_nxt = 1'b1;
          w_hold_nxt  = '0;
          w_state_nxt = KS_IDLE;
        end else if (r_hold == HOLD_W'(LONG_CNT - 1)) begin
          w_long_nxt  = 1'b1;
          w_hold_nxt  = HOLD_W'(LONG_CNT);
          w_state_nxt = KS_LONG;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      KS_LONG: begin
        if (w_s2_fall) begin
          w_hold_nxt  = '0;
          w_state_nxt = KS_IDLE;
        end
      end
      default: w_state_nxt = KS_LOCKED;
    endcase
  end

  always_ff @(posedge clk_db) begin
    if (rst) begin
      r_state <= KS_LOCKED;
      r_hold  <= '0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_short <= w_short_nxt;
      r_long  <= w_long_nxt;
    end
  end

  assign btn_left  = r_btn_left;
  assign btn_right = r_btn_right;
  assign s2_short  = r_short;
  assign s2_long   = r_long;
  assign s2_held   = (r_state != KS_LOCKED) & w_s2_stable;

endmodule

// File: tb/tb_calc_keypad.sv
// Bench for calc_keypad with DB_CNT=3, LONG_CNT=8: directed timing scenarios
// plus randomized key activity compared against a sample-window reference model.
module tb_calc_keypad;

  localparam int DB = 3;
  localparam int LC = 8;

  logic clk_db = 1'b0;
  logic rst    = 1'b1;
  logic key_s0 = 1'b0;
  logic key_s2 = 1'b0;
  logic key_s3 = 1'b0;
  logic btn_left, btn_right, s2_short, s2_long, s2_held;

  int n_checks = 0;
  int n_fail   = 0;

  calc_keypad #(.DB_CNT(DB), .LONG_CNT(LC), .HOLD_W(7)) dut (
    .clk_db   (clk_db),
    .rst      (rst),
    .key_s0   (key_s0),
    .key_s2   (key_s2),
    .key_s3   (key_s3),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .s2_short (s2_short),
    .s2_long  (s2_long),
    .s2_held  (s2_held)
  );

  always #5 clk_db = ~clk_db;

  task automatic tick();
    @(posedge clk_db);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      n_checks++;
      if ({btn_left, btn_right, s2_short, s2_long, s2_held} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset edge %0d: outputs=%b expected 00000", t,
                 {btn_left, btn_right, s2_short, s2_long, s2_held});
      end
    end
    rst = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      n_checks++;
      if ({btn_left, btn_right, s2_short, s2_long, s2_held} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_settle edge %0d: outputs=%b expected 00000", t,
                 {btn_left, btn_right, s2_short, s2_long, s2_held});
      end
    end
  endtask

  task automatic test_s0_press();
    key_s0 = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      n_checks++;
      if (btn_left !== (t == 5) || btn_right !== 1'b0) begin
        n_fail++;
        $display("FAIL s0_press edge %0d: left=%b right=%b expected left=%b right=0",
                 t, btn_left, btn_right, t == 5);
      end
    end
    key_s0 = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      n_checks++;
      if (btn_left !== 1'b0) begin
        n_fail++;
        $display("FAIL s0_release edge %0d: left=%b expected 0", t, btn_left);
      end
    end
  endtask

  task automatic test_s3_bounce();
    for (int t = 1; t <= 20; t++) begin
      key_s3 = (t <= 8) ? logic'(t % 2) : 1'b1;
      tick();
      n_checks++;
      if (btn_right !== (t == 13) || btn_left !== 1'b0) begin
        n_fail++;
        $display("FAIL s3_bounce edge %0d: right=%b left=%b expected right=%b left=0",
                 t, btn_right, btn_left, t == 13);
      end
    end
    key_s3 = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      n_checks++;
      if (btn_right !== 1'b0) begin
        n_fail++;
        $display("FAIL s3_release edge %0d: right=%b expected 0", t, btn_right);
      end
    end
  endtask

  task automatic test_s2_short();
    for (int t = 1; t <= 16; t++) begin
      key_s2 = (t <= 5);
      tick();
      n_checks++;
      if (s2_short !== (t == 10) || s2_long !== 1'b0 || s2_held !== (t >= 5 && t < 10)) begin
        n_fail++;
        $display("FAIL s2_short edge %0d: short=%b long=%b held=%b expected %b 0 %b",
                 t, s2_short, s2_long, s2_held, t == 10, t >= 5 && t < 10);
      end
    end
  endtask

  task automatic test_s2_long();
    for (int t = 1; t <= 32; t++) begin
      key_s2 = (t <= 20);
      tick();
      n_checks++;
      if (s2_long !== (t == 13) || s2_short !== 1'b0 || s2_held !== (t >= 5 && t < 25)) begin
        n_fail++;
        $display("FAIL s2_long edge %0d: long=%b short=%b held=%b expected %b 0 %b",
                 t, s2_long, s2_short, s2_held, t == 13, t >= 5 && t < 25);
      end
    end
  endtask

  task automatic test_collision();
    key_s0 = 1'b1;
    key_s3 = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      if (t == 13) begin
        key_s0 = 1'b0;
        key_s3 = 1'b0;
      end
      tick();
      n_checks++;
      if (btn_left !== 1'b0 || btn_right !== 1'b0) begin
        n_fail++;
        $display("FAIL collision edge %0d: left=%b right=%b expected 0 0", t, btn_left, btn_right);
      end
    end
  endtask

  task automatic test_reset_held();
    key_s2 = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    for (int t = 1; t <= 2; t++) begin
      tick();
      n_checks++;
      if ({btn_left, btn_right, s2_short, s2_long, s2_held} !== 5'b0) begin
        n_fail++;
        $display("FAIL held_reset edge %0d: outputs=%b expected 00000", t,
                 {btn_left, btn_right, s2_short, s2_long, s2_held});
      end
    end
    rst = 1'b0;
    for (int t = 1; t <= 25; t++) begin
      if (t == 16) key_s2 = 1'b0;
      tick();
      n_checks++;
      if ({s2_short, s2_long, s2_held} !== 3'b0) begin
        n_fail++;
        $display("FAIL held_locked edge %0d: short/long/held=%b expected 000", t,
                 {s2_short, s2_long, s2_held});
      end
    end
    for (int t = 1; t <= 14; t++) begin
      key_s2 = (t <= 3);
      tick();
      n_checks++;
      if (s2_short !== (t == 8) || s2_long !== 1'b0 || s2_held !== (t >= 5 && t < 8)) begin
        n_fail++;
        $display("FAIL held_repress edge %0d: short=%b long=%b held=%b expected %b 0 %b",
                 t, s2_short, s2_long, s2_held, t == 8, t >= 5 && t < 8);
      end
    end
  endtask

  // Reference: a level is accepted once the last DB synchronized samples all
  // disagree with it; S2 presses are timed from the accepted rise.
  task automatic test_random();
    bit hist[3][DB+2];
    bit st[3];
    bit lvl[3];
    int dur[3];
    bit rose[3], fell[3];
    bit agree, prev_st2, locked, pressing, fired;
    bit e_left, e_right, e_short, e_long, e_held;
    int rise_e;

    for (int k = 0; k < 3; k++) begin
      lvl[k] = 1'($urandom_range(0, 1));
      dur[k] = $urandom_range(1, 10);
      st[k]  = 1'b1;
      for (int j = 0; j < DB + 2; j++) hist[k][j] = 1'b0;
    end
    key_s0 = lvl[0];
    key_s2 = lvl[1];
    key_s3 = lvl[2];
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    locked   = 1'b1;
    pressing = 1'b0;
    fired    = 1'b0;
    rise_e   = 0;

    for (int e = 0; e < 900; e++) begin
      @(posedge clk_db);
      for (int k = 0; k < 3; k++) begin
        for (int j = DB + 1; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = lvl[k];
      end
      prev_st2 = st[1];
      for (int k = 0; k < 3; k++) begin
        agree = 1'b1;
        for (int j = 2; j <= DB + 1; j++) if (hist[k][j] == st[k]) agree = 1'b0;
        rose[k] = agree && !st[k];
        fell[k] = agree && st[k];
        if (agree) st[k] = !st[k];
      end
      e_left  = rose[0] && !rose[2];
      e_right = rose[2] && !rose[0];
      e_short = 1'b0;
      e_long  = 1'b0;
      if (locked) begin
        if (!prev_st2) locked = 1'b0;
      end else if (!pressing) begin
        if (rose[1]) begin
          pressing = 1'b1;
          fired    = 1'b0;
          rise_e   = e;
        end
      end else begin
        if (fell[1]) begin
          e_short  = !fired;
          pressing = 1'b0;
        end else if (!fired && (e - rise_e) == LC) begin
          e_long = 1'b1;
          fired  = 1'b1;
        end
      end
      e_held = !locked && st[1];

      #1;
      n_checks++;
      if (btn_left !== e_left) begin
        n_fail++;
        $display("FAIL rand_left cycle %0d: got %b expected %b", e, btn_left, e_left);
      end
      n_checks++;
      if (btn_right !== e_right) begin
        n_fail++;
        $display("FAIL rand_right cycle %0d: got %b expected %b", e, btn_right, e_right);
      end
      n_checks++;
      if (s2_short !== e_short) begin
        n_fail++;
        $display("FAIL rand_short cycle %0d: got %b expected %b", e, s2_short, e_short);
      end
      n_checks++;
      if (s2_long !== e_long) begin
        n_fail++;
        $display("FAIL rand_long cycle %0d: got %b expected %b", e, s2_long, e_long);
      end
      n_checks++;
      if (s2_held !== e_held) begin
        n_fail++;
        $display("FAIL rand_held cycle %0d: got %b expected %b", e, s2_held, e_held);
      end

      for (int k = 0; k < 3; k++) begin
        dur[k]--;
        if (dur[k] == 0) begin
          lvl[k] = !lvl[k];
          dur[k] = (k == 1) ? $urandom_range(1, 16) : $urandom_range(1, 10);
        end
      end
      key_s0 = lvl[0];
      key_s2 = lvl[1];
      key_s3 = lvl[2];
    end
  endtask

  initial begin
    test_reset();
    test_s0_press();
    test_s3_bounce();
    test_s2_short();
    test_s2_long();
    test_collision();
    test_reset_held();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
